// File: rtl/pipe_pkg.sv
// Shared pipeline types: hazard FSM states, MemtoReg encodings
// and the hazard control bundle driven into the pipeline registers.
package pipe_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } hz_state_e;

    localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
    localparam logic [1:0] MEMTOREG_LOAD = 2'b01;
    localparam logic [1:0] MEMTOREG_PC   = 2'b10;

    typedef struct packed {
        logic pc_wr;
        logic ifid_wr;
        logic ifid_flush;
        logic idex_wr;
        logic idex_flush;
        logic exmem_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t HZ_IDLE = '{
        pc_wr:        1'b1,
        ifid_wr:      1'b1,
        ifid_flush:   1'b0,
        idex_wr:      1'b1,
        idex_flush:   1'b0,
        exmem_bubble: 1'b0
    };

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for hazard performance statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    // count qualifying cycles, hold once saturated
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + W'(1);
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use, branch/jump flush,
// MDU occupancy of EX and data-memory wait, plus perf counters.
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_jump_i,
    input  logic [1:0]       ex_memtoreg_i,
    input  logic             ex_regwr_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             ex_branch_taken_i,
    input  logic             ex_mdu_i,
    input  logic             dmem_wait_i,
    output logic             pc_wr_o,
    output logic             ifid_wr_o,
    output logic             ifid_flush_o,
    output logic             idex_wr_o,
    output logic             idex_flush_o,
    output logic             exmem_bubble_o,
    output logic             mdu_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // first MDU cycle stalls in RUN, so the wait state covers LAT-2 more
    localparam logic [3:0] MCNT_INIT = 4'(MDU_LAT - 2);
    localparam bit         MDU_MULTI = (MDU_LAT > 1);

    hz_state_e  state_q, state_d;
    logic [3:0] mcnt_q, mcnt_d;
    hz_ctrl_t   ctrl;
    logic       load_use;

    assign load_use = (ex_memtoreg_i == MEMTOREG_LOAD)
                    && ex_regwr_i
                    && (ex_rt_i != 5'd0)
                    && ((ex_rt_i == id_rs_i)
                        || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

    // prioritised hazard resolution and FSM next state
    always_comb begin
        ctrl    = HZ_IDLE;
        state_d = state_q;
        mcnt_d  = mcnt_q;
        if (reset) begin
            ctrl = HZ_IDLE;
        end else if (dmem_wait_i) begin
            ctrl.pc_wr   = 1'b0;
            ctrl.ifid_wr = 1'b0;
            ctrl.idex_wr = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ex_mdu_i && MDU_MULTI) begin
                        ctrl.pc_wr        = 1'b0;
                        ctrl.ifid_wr      = 1'b0;
                        ctrl.idex_wr      = 1'b0;
                        ctrl.exmem_bubble = 1'b1;
                        state_d           = MDU_WAIT;
                        mcnt_d            = MCNT_INIT;
                    end else if (ex_branch_taken_i && !ex_mdu_i) begin
                        ctrl.ifid_flush = 1'b1;
                        ctrl.idex_flush = 1'b1;
                    end else if (load_use) begin
                        ctrl.pc_wr      = 1'b0;
                        ctrl.ifid_wr    = 1'b0;
                        ctrl.idex_flush = 1'b1;
                    end else if (id_jump_i) begin
                        ctrl.ifid_flush = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (mcnt_q != 4'd0) begin
                        ctrl.pc_wr        = 1'b0;
                        ctrl.ifid_wr      = 1'b0;
                        ctrl.idex_wr      = 1'b0;
                        ctrl.exmem_bubble = 1'b1;
                        mcnt_d            = mcnt_q - 4'd1;
                    end else begin
                        state_d = RUN;
                    end
                end
            endcase
        end
    end

    // FSM state and MDU down-counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            mcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign pc_wr_o        = ctrl.pc_wr;
    assign ifid_wr_o      = ctrl.ifid_wr;
    assign ifid_flush_o   = ctrl.ifid_flush;
    assign idex_wr_o      = ctrl.idex_wr;
    assign idex_flush_o   = ctrl.idex_flush;
    assign exmem_bubble_o = ctrl.exmem_bubble;
    assign mdu_busy_o     = (state_q == MDU_WAIT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!ctrl.pc_wr),
        .q     (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl.ifid_flush),
        .q     (flush_cnt_o)
    );

endmodule
